// File: rtl/mod_reduce_pkg.sv
// rtl/mod_reduce_pkg.sv - shared constants, state encoding and residue helpers for mod_reduce_seq
package mod_reduce_pkg;

    localparam int MOD    = 503;
    localparam int XW     = 200;
    localparam int CW     = 6;
    localparam int RW     = 9;
    localparam int NCHUNK = (XW + CW - 1) / CW;
    localparam int IDXW   = $clog2(NCHUNK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // (c << (CW*k)) mod MOD by repeated doubling, so no wide constant is ever formed
    function automatic logic [RW-1:0] chunk_res(input int k, input int c);
        int r;
        r = c % MOD;
        for (int i = 0; i < CW * k; i++) begin
            r = (r * 2) % MOD;
        end
        return RW'(r);
    endfunction

    function automatic logic [RW-1:0] modadd(input logic [RW-1:0] a, input logic [RW-1:0] b);
        logic [RW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= (RW+1)'(MOD)) ? RW'(s - (RW+1)'(MOD)) : s[RW-1:0];
    endfunction

endpackage

// File: rtl/mod_chunk_lut.sv
// rtl/mod_chunk_lut.sv - time-shared chunk residue ROM indexed by chunk position and chunk value
module mod_chunk_lut
    import mod_reduce_pkg::*;
(
    input  logic [IDXW-1:0] idx,
    input  logic [CW-1:0]   chunk,
    output logic [RW-1:0]   res
);

    localparam int DEPTH = NCHUNK * (2 ** CW);

    logic [RW-1:0] rom [DEPTH];

    for (genvar k = 0; k < NCHUNK; k++) begin : gen_k
        for (genvar c = 0; c < 2 ** CW; c++) begin : gen_c
            assign rom[k * (2 ** CW) + c] = chunk_res(k, c);
        end
    end

    // idx runs one past the last chunk while the result waits in DONE
    always_comb begin
        res = '0;
        if (idx < IDXW'(NCHUNK)) begin
            res = rom[{idx, chunk}];
        end
    end

endmodule

// File: rtl/mod_reduce_seq.sv
// rtl/mod_reduce_seq.sv - sequential x mod MOD reducer, one chunk per cycle, valid/ready both sides
module mod_reduce_seq
    import mod_reduce_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_z,
    output logic          busy
);

    state_t          state;
    logic [XW-1:0]   xsr;
    logic [RW-1:0]   acc;
    logic [IDXW-1:0] idx;
    logic [RW-1:0]   lut_res;
    logic [RW-1:0]   sum;

    mod_chunk_lut u_lut (
        .idx   (idx),
        .chunk (xsr[CW-1:0]),
        .res   (lut_res)
    );

    assign sum  = modadd(acc, lut_res);
    assign busy = (state == RUN);
    // flush blocks the accept so a same-cycle handshake never loads an operand
    assign in_ready = !flush && ((state == IDLE) || ((state == DONE) && out_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            xsr       <= '0;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_z     <= '0;
        end else if (flush) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xsr   <= in_x;
                        acc   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= sum;
                    xsr <= xsr >> CW;
                    idx <= idx + 1'b1;
                    if (idx == IDXW'(NCHUNK - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_z     <= sum;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            xsr   <= in_x;
                            acc   <= '0;
                            idx   <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// tb/tb_mod_reduce_seq.sv - scoreboard bench for mod_reduce_seq
module tb_mod_reduce_seq;

    localparam int MODV = 503;
    localparam int LAT  = 35;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [199:0] in_x = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [8:0]   out_z;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit prev_ov = 1'b0;
    bit rand_ready = 1'b0;

    int exp_q[$];
    int lat_q[$];

    mod_reduce_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    function automatic int gold(input logic [199:0] x);
        int r;
        r = 0;
        for (int i = 199; i >= 0; i--) r = (r * 2 + int'(x[i])) % MODV;
        return r;
    endfunction

    // monitor: all sampling on the falling edge, inputs only change just after the rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready && !flush) lat_q.push_back(cyc);
            if (out_valid && !prev_ov) begin
                if (lat_q.size() == 0) check("unexpected_out_valid", 1, 0);
                else check("latency", cyc - lat_q.pop_front(), LAT);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_result", 1, 0);
                else check("out_z", int'(out_z), exp_q.pop_front());
            end
            check("acc_lt_mod", int'(dut.acc < 9'(MODV)), 1);
        end
        prev_ov = out_valid;
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [199:0] x, input int expv);
        bit got;
        int n;
        @(posedge clk); #1;
        in_x = x;
        in_valid = 1'b1;
        exp_q.push_back(expv);
        n = 0;
        got = 1'b0;
        while (!got && n < 2000) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!got) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [199:0] x;
        logic [223:0] w;
        int n;

        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_z", int'(out_z), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);

        // residues within one chunk and around the modulus
        out_ready = 1'b1;
        send(200'd0, 0);
        send(200'd503, 0);
        send(200'd1006, 0);
        send(200'd502, 502);
        send(200'd1011, 5);
        send(200'd512, 9);
        send(200'd4096, 72);
        x = '1;
        send(x, gold(x));
        drain();

        // backpressure then back-to-back reload
        out_ready = 1'b0;
        send(200'd1011, 5);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        check("bp_out_valid", int'(out_valid), 1);
        fork send(200'd512, 9); join_none
        repeat (10) begin
            @(negedge clk);
            check("bp_out_z_stable", int'(out_z), 5);
            check("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b2b_busy", int'(busy), 1);
        check("b2b_out_valid", int'(out_valid), 0);
        drain();

        // flush in RUN at idx 17
        @(posedge clk); #1;
        in_x = 200'd4096; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", int'(busy), 0);
        check("flush_in_ready", int'(in_ready), 1);
        lat_q.delete();
        repeat (40) @(negedge clk);
        check("flush_no_result", int'(out_valid), 0);
        // flush with a concurrent offer in IDLE must not accept
        @(posedge clk); #1;
        in_x = 200'd7; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_wins_busy", int'(busy), 0);
        send(200'd4096, 72);
        drain();

        // async reset mid-RUN
        @(posedge clk); #1;
        in_x = 200'd1011; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_z", int'(out_z), 0);
        check("arst_busy", int'(busy), 0);
        lat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(200'd502, 502);
        drain();

        // random operands with stalls on both sides
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            w = '0;
            for (int j = 0; j < 7; j++) w = {w[191:0], 32'($urandom())};
            x = w[199:0];
            if (i % 50 == 0) x = '0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(x, gold(x));
        end
        drain();
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("lat_q_empty", lat_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
